// File: rtl/sys_feeder_pkg.sv
// Shared types and helpers for the systolic skew feeder: FSM state encoding and beat count.
package sys_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } feeder_state_e;

    // FEED covers 2*ms-1 beats, DRAIN adds ms-1 all-zero beats to flush the array.
    function automatic int beat_count(input int ms);
        return 3 * ms - 2;
    endfunction

endpackage

// File: rtl/sys_skew_lane.sv
// One skew lane: given the beat counter, emits vec_i[k-LANE] when that index is in range, else 0.
module sys_skew_lane #(
    parameter int n           = 8,
    parameter int matrix_size = 4,
    parameter int LANE        = 0,
    parameter int KW          = 4
) (
    input  logic                en_i,
    input  logic [KW-1:0]       k_i,
    input  logic signed [n-1:0] vec_i [matrix_size],
    output logic signed [n-1:0] elem_o
);

    always_comb begin
        elem_o = '0;
        for (int e = 0; e < matrix_size; e++) begin
            if (en_i && (k_i == KW'(e + LANE))) begin
                elem_o = vec_i[e];
            end
        end
    end

endmodule

// File: rtl/sys_skew_feeder.sv
// Captures an A/B matrix pair and streams them diagonally skewed onto a systolic array's edges.
// Optional input stall is compiled in with SYS_SKEW_FEEDER_STALL_EN.
module sys_skew_feeder
    import sys_feeder_pkg::*;
#(
    parameter int n           = 8,
    parameter int matrix_size = 4
) (
    input  logic                clk,
    input  logic                rst,
`ifdef SYS_SKEW_FEEDER_STALL_EN
    input  logic                stall,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [n-1:0] dataA_in [matrix_size][matrix_size],
    input  logic signed [n-1:0] dataB_in [matrix_size][matrix_size],
    output logic signed [n-1:0] a_edge [matrix_size],
    output logic signed [n-1:0] b_edge [matrix_size],
    output logic                edge_valid,
    output logic                edge_first,
    output logic                edge_last
);

    localparam int KW = $clog2(3 * matrix_size);
    localparam logic [KW-1:0] K_FEED_END = KW'(2 * matrix_size - 2);
    localparam logic [KW-1:0] K_LAST     = KW'(beat_count(matrix_size) - 1);

    feeder_state_e state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic signed [n-1:0] a_q [matrix_size][matrix_size];
    logic signed [n-1:0] a_d [matrix_size][matrix_size];
    logic signed [n-1:0] b_q [matrix_size][matrix_size];
    logic signed [n-1:0] b_d [matrix_size][matrix_size];
    logic signed [n-1:0] b_col [matrix_size][matrix_size];
    logic signed [n-1:0] lane_a [matrix_size];
    logic signed [n-1:0] lane_b [matrix_size];
    logic edge_valid_q, edge_first_q, edge_last_q;
    logic run;

`ifdef SYS_SKEW_FEEDER_STALL_EN
    assign run = ~stall;
`else
    assign run = 1'b1;
`endif

    assign in_ready   = (state_q == IDLE) && run;
    assign edge_valid = edge_valid_q && run;
    assign edge_first = edge_first_q;
    assign edge_last  = edge_last_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        if (run) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d = FEED;
                        k_d     = '0;
                        a_d     = dataA_in;
                        b_d     = dataB_in;
                    end
                end
                FEED: begin
                    k_d = k_q + 1'b1;
                    if (k_q == K_FEED_END) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (k_q == K_LAST) begin
                        state_d = IDLE;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    k_d     = '0;
                end
            endcase
        end
    end

    // Lanes look at next-state values so each beat lands in the output registers on its own edge.
    for (genvar gi = 0; gi < matrix_size; gi++) begin : g_lane
        for (genvar gr = 0; gr < matrix_size; gr++) begin : g_col
            assign b_col[gi][gr] = b_d[gr][gi];
        end

        sys_skew_lane #(
            .n(n), .matrix_size(matrix_size), .LANE(gi), .KW(KW)
        ) u_lane_a (
            .en_i(state_d != IDLE), .k_i(k_d), .vec_i(a_d[gi]), .elem_o(lane_a[gi])
        );

        sys_skew_lane #(
            .n(n), .matrix_size(matrix_size), .LANE(gi), .KW(KW)
        ) u_lane_b (
            .en_i(state_d != IDLE), .k_i(k_d), .vec_i(b_col[gi]), .elem_o(lane_b[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            a_q          <= '{default: '0};
            b_q          <= '{default: '0};
            a_edge       <= '{default: '0};
            b_edge       <= '{default: '0};
            edge_valid_q <= 1'b0;
            edge_first_q <= 1'b0;
            edge_last_q  <= 1'b0;
        end else if (run) begin
            state_q      <= state_d;
            k_q          <= k_d;
            a_q          <= a_d;
            b_q          <= b_d;
            a_edge       <= lane_a;
            b_edge       <= lane_b;
            edge_valid_q <= (state_d != IDLE);
            edge_first_q <= (state_d == FEED) && (k_d == '0);
            edge_last_q  <= (state_d == DRAIN) && (k_d == K_LAST);
        end
    end

endmodule

// File: tb/tb_sys_skew_feeder.sv
// Directed bench for sys_skew_feeder (4x4, 8-bit); stall scenario compiled with SYS_SKEW_FEEDER_STALL_EN.
module tb_sys_skew_feeder;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_ready;
    logic signed [7:0] dataA_in [4][4];
    logic signed [7:0] dataB_in [4][4];
    logic signed [7:0] a_edge [4];
    logic signed [7:0] b_edge [4];
    logic edge_valid, edge_first, edge_last;
`ifdef SYS_SKEW_FEEDER_STALL_EN
    logic stall;
`endif

    logic signed [7:0] ma [4][4];
    logic signed [7:0] mb [4][4];
    logic signed [7:0] ma2 [4][4];
    int tests_run = 0;
    int tests_failed = 0;

    sys_skew_feeder #(.n(8), .matrix_size(4)) dut (
        .clk(clk),
        .rst(rst),
`ifdef SYS_SKEW_FEEDER_STALL_EN
        .stall(stall),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dataA_in(dataA_in),
        .dataB_in(dataB_in),
        .a_edge(a_edge),
        .b_edge(b_edge),
        .edge_valid(edge_valid),
        .edge_first(edge_first),
        .edge_last(edge_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [7:0] exp_a(input int i, input int k);
        if (k - i >= 0 && k - i < 4) return ma[i][k-i];
        return 8'sd0;
    endfunction

    function automatic logic signed [7:0] exp_b(input int j, input int k);
        if (k - j >= 0 && k - j < 4) return mb[k-j][j];
        return 8'sd0;
    endfunction

    task automatic load_inputs();
        dataA_in = ma;
        dataB_in = mb;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_timeout in_ready=%b required=1", name, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests_run++;
        if ({in_ready, edge_valid, edge_first, edge_last} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_ctrl got=%b required=1000", {in_ready, edge_valid, edge_first, edge_last});
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (a_edge[i] !== 8'sd0 || b_edge[i] !== 8'sd0) begin
                tests_failed++;
                $display("FAIL reset_edge lane=%0d a=%0d b=%0d required=0", i, a_edge[i], b_edge[i]);
            end
        end
        $display("[TB] reset done");
    endtask

    task automatic test_feed();
        logic signed [7:0] h3a [4];
        logic signed [7:0] h3b [4];
        load_inputs();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        // Captured operands must not follow the input bus after the handshake.
        dataA_in = ma2;
        dataB_in = ma2;
        h3a = '{8'sd4, 8'sd7, 8'sd10, 8'sd13};
        h3b = '{8'sd4, 8'sd3, -8'sd2, 8'sd1};
        for (int k = 0; k < 10; k++) begin
            tests_run++;
            if ({edge_valid, edge_first, edge_last, in_ready} !== {1'b1, k == 0, k == 9, 1'b0}) begin
                tests_failed++;
                $display("FAIL feed_ctrl beat=%0d v/f/l/rdy=%b required=%b", k,
                         {edge_valid, edge_first, edge_last, in_ready}, {1'b1, k == 0, k == 9, 1'b0});
            end
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (a_edge[i] !== exp_a(i, k) || b_edge[i] !== exp_b(i, k)) begin
                    tests_failed++;
                    $display("FAIL feed_data beat=%0d lane=%0d a=%0d b=%0d required a=%0d b=%0d",
                             k, i, a_edge[i], b_edge[i], exp_a(i, k), exp_b(i, k));
                end
            end
            if (k == 0) begin
                tests_run++;
                if (a_edge[0] !== -8'sd1 || b_edge[0] !== 8'sd1 || a_edge[1] !== 8'sd0 || b_edge[3] !== 8'sd0) begin
                    tests_failed++;
                    $display("FAIL beat0_vec a0=%0d b0=%0d a1=%0d b3=%0d required -1 1 0 0",
                             a_edge[0], b_edge[0], a_edge[1], b_edge[3]);
                end
            end
            if (k == 3) begin
                for (int i = 0; i < 4; i++) begin
                    tests_run++;
                    if (a_edge[i] !== h3a[i] || b_edge[i] !== h3b[i]) begin
                        tests_failed++;
                        $display("FAIL beat3_vec lane=%0d a=%0d b=%0d required a=%0d b=%0d",
                                 i, a_edge[i], b_edge[i], h3a[i], h3b[i]);
                    end
                end
            end
            if (k == 6) begin
                tests_run++;
                if (a_edge[3] !== 8'sd15 || b_edge[3] !== 8'sd4 || a_edge[2] !== 8'sd0 || b_edge[0] !== 8'sd0) begin
                    tests_failed++;
                    $display("FAIL beat6_vec a3=%0d b3=%0d a2=%0d b0=%0d required 15 4 0 0",
                             a_edge[3], b_edge[3], a_edge[2], b_edge[0]);
                end
            end
            $display("[TB] feed beat %0d a=%0d,%0d,%0d,%0d b=%0d,%0d,%0d,%0d", k,
                     a_edge[0], a_edge[1], a_edge[2], a_edge[3], b_edge[0], b_edge[1], b_edge[2], b_edge[3]);
            tick();
        end
        tests_run++;
        if ({edge_valid, edge_last, in_ready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL feed_end v/l/rdy=%b required=001", {edge_valid, edge_last, in_ready});
        end
    endtask

    task automatic test_reset_abort();
        load_inputs();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        tests_run++;
        if (a_edge[1] !== 8'sd8) begin
            tests_failed++;
            $display("FAIL abort_beat4 a1=%0d required=8", a_edge[1]);
        end
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        tests_run++;
        if ({in_ready, edge_valid, edge_first, edge_last} !== 4'b1000 || a_edge[1] !== 8'sd0 || b_edge[1] !== 8'sd0) begin
            tests_failed++;
            $display("FAIL abort_state rdy/v/f/l=%b a1=%0d b1=%0d required 1000 0 0",
                     {in_ready, edge_valid, edge_first, edge_last}, a_edge[1], b_edge[1]);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (edge_first !== 1'b1 || edge_valid !== 1'b1 || a_edge[0] !== -8'sd1 || b_edge[0] !== 8'sd1) begin
            tests_failed++;
            $display("FAIL abort_restart f=%b v=%b a0=%0d b0=%0d required 1 1 -1 1",
                     edge_first, edge_valid, a_edge[0], b_edge[0]);
        end
        $display("[TB] reset abort and restart done");
        wait_idle("abort");
    endtask

    task automatic test_back_to_back();
        load_inputs();
        in_valid = 1'b1;
        tick();
        dataA_in = ma2;
        for (int k = 0; k < 10; k++) begin
            tests_run++;
            if (edge_valid !== 1'b1 || a_edge[k % 4] !== exp_a(k % 4, k)) begin
                tests_failed++;
                $display("FAIL b2b_job1 beat=%0d v=%b a=%0d required 1 %0d", k, edge_valid, a_edge[k % 4], exp_a(k % 4, k));
            end
            tick();
        end
        tests_run++;
        if ({edge_valid, in_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL b2b_bubble v/rdy=%b required=01", {edge_valid, in_ready});
        end
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({edge_valid, edge_first} !== 2'b11 || a_edge[0] !== ma2[0][0]) begin
            tests_failed++;
            $display("FAIL b2b_job2 v/f=%b a0=%0d required 11 %0d", {edge_valid, edge_first}, a_edge[0], ma2[0][0]);
        end
        $display("[TB] back-to-back second job started a0=%0d", a_edge[0]);
        wait_idle("b2b");
    endtask

`ifdef SYS_SKEW_FEEDER_STALL_EN
    task automatic test_stall();
        int valid_cnt = 0;
        load_inputs();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            stall = (c >= 2 && c < 5);
            #1;
            if (edge_valid) valid_cnt++;
            if (c >= 2 && c < 6) begin
                tests_run++;
                if (edge_valid !== (c == 5) || a_edge[2] !== 8'sd9) begin
                    tests_failed++;
                    $display("FAIL stall_hold cyc=%0d v=%b a2=%0d required %b 9", c, edge_valid, a_edge[2], c == 5);
                end
            end
            tick();
        end
        stall = 1'b0;
        tests_run++;
        if (valid_cnt !== 10) begin
            tests_failed++;
            $display("FAIL stall_count got=%0d required=10", valid_cnt);
        end
        $display("[TB] stall scenario valid beats=%0d", valid_cnt);
    endtask
`endif

    initial begin
        int ia [4][4] = '{'{-1, 2, 3, 4}, '{5, 6, 7, 8}, '{9, 10, -11, 12}, '{13, 14, 15, 15}};
        int ib [4][4] = '{'{1, 1, 1, 1}, '{2, 2, -2, 2}, '{3, 3, 3, 3}, '{4, 4, 4, 4}};
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                ma[i][j]  = 8'(ia[i][j]);
                mb[i][j]  = 8'(ib[i][j]);
                ma2[i][j] = 8'(20 + 4 * i + j);
            end
        end
        rst = 1'b0;
        in_valid = 1'b0;
        dataA_in = ma;
        dataB_in = mb;
`ifdef SYS_SKEW_FEEDER_STALL_EN
        stall = 1'b0;
`endif
        test_reset();
        test_feed();
        test_reset_abort();
        test_back_to_back();
`ifdef SYS_SKEW_FEEDER_STALL_EN
        test_stall();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required finish before 200000", $time);
        $fatal(1, "timeout");
    end

endmodule
